// File: rtl/ccff_stream_loader.sv
// rtl/ccff_stream_loader.sv - configuration-chain load/readback controller
//
// Purpose: serialises bitstream words into a CHAIN_LEN-bit ccff chain (LSB first)
// and reads the chain back non-destructively by rotating tail into head.
// Ports:
//   prog_clk, pReset                 clock, synchronous active-high reset
//   start_load, start_read           operation requests, sampled in IDLE only
//   in_data/in_valid/in_last/in_ready    load word stream
//   out_data/out_valid/out_last/out_ready readback word stream
//   ccff_head, ccff_tail, ccff_shift_en  chain serial interface
//   busy, done, error                status
module ccff_stream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start_load,
  input  logic              start_read,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CHAIN_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LWAIT,
    S_LSHIFT,
    S_RSHIFT,
    S_ROUT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;      // chain bits shifted so far
  logic [BW-1:0]     bit_q, bit_d;      // bit position within current word
  logic [WORD_W-1:0] word_q, word_d;    // captured load word
  logic              last_q, last_d;    // captured in_last
  logic [WORD_W-1:0] rdata_q, rdata_d;  // readback word assembly
  logic              err_q, err_d;

  // A word segment ends at the word boundary or when the chain is full,
  // whichever comes first; excess bits of a final word are never shifted.
  logic seg_end;
  assign seg_end = (bit_q == LAST_BIT) || (cnt_q == LAST_CNT);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d = S_LWAIT;
          err_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (start_read) begin
          state_d = S_RSHIFT;
          err_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          rdata_d = '0;
        end
      end

      S_LWAIT: begin
        if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          state_d = S_LSHIFT;
        end
      end

      S_LSHIFT: begin
        cnt_d = cnt_q + CW'(1);
        bit_d = bit_q + BW'(1);
        if (seg_end) begin
          bit_d = '0;
          if (cnt_q == LAST_CNT) begin
            // Chain full: a missing in_last means the stream is overlong.
            state_d = last_q ? S_DONE : S_ERR;
            err_d   = ~last_q;
          end else if (last_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_LWAIT;
          end
        end
      end

      S_RSHIFT: begin
        rdata_d[bit_q] = ccff_tail;
        cnt_d = cnt_q + CW'(1);
        bit_d = bit_q + BW'(1);
        if (seg_end) begin
          bit_d   = '0;
          state_d = S_ROUT;
        end
      end

      S_ROUT: begin
        if (out_ready) begin
          // Clear so a final partial word returns zeros in its upper bits.
          rdata_d = '0;
          state_d = (cnt_q == FULL_CNT) ? S_DONE : S_RSHIFT;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Chain controls decode registered state only; during readback the head
  // is muxed straight from the tail so the chain rotates.
  assign ccff_shift_en = (state_q == S_LSHIFT) || (state_q == S_RSHIFT);
  assign ccff_head     = (state_q == S_LSHIFT) ? word_q[bit_q] :
                         (state_q == S_RSHIFT) ? ccff_tail : 1'b0;

  assign in_ready  = (state_q == S_LWAIT);
  assign out_valid = (state_q == S_ROUT);
  assign out_data  = (state_q == S_ROUT) ? rdata_q : '0;
  assign out_last  = (state_q == S_ROUT) && (cnt_q == FULL_CNT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = err_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// tb/tb_ccff_stream_loader.sv - directed table-driven bench for ccff_stream_loader
module tb_ccff_stream_loader;

  localparam int WW = 8;
  localparam int CL = 20;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start_load, start_read;
  logic [WW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [WW-1:0] out_data;
  logic          out_valid, out_last, out_ready;
  logic          ccff_head, ccff_tail, ccff_shift_en;
  logic          busy, done, error;

  ccff_stream_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .pReset(pReset),
    .start_load(start_load), .start_read(start_read),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
    .busy(busy), .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  // Attached chain: head enters at bit 0, tail leaves from bit CL-1.
  logic [CL-1:0] chain_q;
  int            shift_cnt = 0;
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain_q   <= {chain_q[CL-2:0], ccff_head};
      shift_cnt <= shift_cnt + 1;
    end
  end
  assign ccff_tail = chain_q[CL-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         exp_k;
    logic [7:0] exp_head;
    logic       exp_done;
    logic       exp_err;
    logic       exp_ready;
  } lvec_t;

  typedef struct {
    logic [7:0] exp_data;
    logic       exp_last;
    int         exp_k;
  } rvec_t;

  lvec_t         lv[8];
  rvec_t         rv[3];
  logic [CL-1:0] exp_img;

  task automatic load_word(input logic [7:0] d, input logic l,
                           output int k, output logic [7:0] hb);
    int guard;
    k = 0; hb = 8'h00; guard = 0;
    while (!in_ready && guard < 50) begin @(negedge prog_clk); guard++; end
    chk("load_ready_timeout", 32'(guard < 50), 32'd1);
    in_data = d; in_valid = 1'b1; in_last = l;
    @(negedge prog_clk);
    in_valid = 1'b0; in_last = 1'b0;
    guard = 0;
    while (ccff_shift_en && guard < 50) begin
      if (k < 8) hb[k] = ccff_head;
      k++;
      guard++;
      @(negedge prog_clk);
    end
  endtask

  task automatic run_load(input int first, input int n);
    int         k;
    logic [7:0] hb;
    start_load = 1'b1;
    @(negedge prog_clk);
    start_load = 1'b0;
    chk("start_clears_error", 32'(error), 32'd0);
    for (int i = first; i < first + n; i++) begin
      load_word(lv[i].data, lv[i].last, k, hb);
      chk($sformatf("load%0d_shifts", i), 32'(k), 32'(lv[i].exp_k));
      chk($sformatf("load%0d_head_bits", i), 32'(hb), 32'(lv[i].exp_head));
      chk($sformatf("load%0d_done", i), 32'(done), 32'(lv[i].exp_done));
      chk($sformatf("load%0d_error", i), 32'(error), 32'(lv[i].exp_err));
      chk($sformatf("load%0d_in_ready", i), 32'(in_ready), 32'(lv[i].exp_ready));
    end
  endtask

  task automatic read_word(input int hold, output logic [7:0] d, output logic l,
                           output int k, output int bad);
    int guard;
    k = 0; bad = 0; guard = 0;
    while (!out_valid && guard < 50) begin
      if (ccff_shift_en) k++;
      guard++;
      @(negedge prog_clk);
    end
    chk("read_valid_timeout", 32'(guard < 50), 32'd1);
    d = out_data; l = out_last;
    for (int h = 0; h < hold; h++) begin
      @(negedge prog_clk);
      if (!out_valid || out_data !== d || ccff_shift_en) bad++;
    end
    out_ready = 1'b1;
    @(negedge prog_clk);
    out_ready = 1'b0;
  endtask

  task automatic run_read(input int hold0);
    logic [7:0] d;
    logic       l;
    int         k, bad;
    start_read = 1'b1;
    @(negedge prog_clk);
    start_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      read_word((i == 0) ? hold0 : 0, d, l, k, bad);
      chk($sformatf("read%0d_data", i), 32'(d), 32'(rv[i].exp_data));
      chk($sformatf("read%0d_last", i), 32'(l), 32'(rv[i].exp_last));
      chk($sformatf("read%0d_shifts", i), 32'(k), 32'(rv[i].exp_k));
      chk($sformatf("read%0d_done", i), 32'(done), 32'(rv[i].exp_last));
      if (hold0 > 0 && i == 0) chk("backpressure_hold", 32'(bad), 32'd0);
    end
    @(negedge prog_clk);
    chk("read_idle_busy", 32'(busy), 32'd0);
    chk("read_chain_intact", 32'(chain_q), 32'(exp_img));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] stream;
    int          s0, acc;

    lv[0] = '{8'hA5, 1'b0, 8, 8'hA5, 1'b0, 1'b0, 1'b1};
    lv[1] = '{8'h3C, 1'b0, 8, 8'h3C, 1'b0, 1'b0, 1'b1};
    lv[2] = '{8'h0F, 1'b1, 4, 8'h0F, 1'b1, 1'b0, 1'b0};
    lv[3] = '{8'hA5, 1'b0, 8, 8'hA5, 1'b0, 1'b0, 1'b1};
    lv[4] = '{8'h3C, 1'b1, 8, 8'h3C, 1'b0, 1'b1, 1'b0};
    lv[5] = '{8'hA5, 1'b0, 8, 8'hA5, 1'b0, 1'b0, 1'b1};
    lv[6] = '{8'h3C, 1'b0, 8, 8'h3C, 1'b0, 1'b0, 1'b1};
    lv[7] = '{8'hFF, 1'b0, 4, 8'h0F, 1'b0, 1'b1, 1'b0};
    rv[0] = '{8'hA5, 1'b0, 8};
    rv[1] = '{8'h3C, 1'b0, 8};
    rv[2] = '{8'h0F, 1'b1, 4};

    // First loaded bit ends up at the tail.
    stream = 24'h0F3CA5;
    for (int i = 0; i < CL; i++) exp_img[CL-1-i] = stream[i];

    pReset = 1'b1; start_load = 1'b0; start_read = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("reset_outputs",
        32'({busy, done, error, in_ready, out_valid, out_last, ccff_shift_en, ccff_head, out_data}),
        32'd0);
    pReset = 1'b0;
    @(negedge prog_clk);

    // Full load, then two readbacks (second with backpressure).
    run_load(0, 3);
    @(negedge prog_clk);
    chk("load_idle_done_low", 32'({busy, done}), 32'd0);
    chk("load_chain_image", 32'(chain_q), 32'(exp_img));
    run_read(0);
    run_read(10);

    // Short stream: error sticks in IDLE, no done.
    run_load(3, 2);
    @(negedge prog_clk);
    chk("short_error_sticky", 32'({busy, done, error}), 32'b001);

    // Overlong stream: extra word must never be accepted.
    run_load(5, 3);
    in_data = 8'h55; in_valid = 1'b1; in_last = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge prog_clk);
      if (in_ready) acc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("overlong_no_accept", 32'(acc), 32'd0);
    chk("overlong_error_sticky", 32'({busy, error}), 32'b01);

    // Reset after 5 load shifts.
    start_load = 1'b1;
    @(negedge prog_clk);
    start_load = 1'b0;
    in_data = 8'hA5; in_valid = 1'b1; in_last = 1'b0;
    @(negedge prog_clk);
    in_valid = 1'b0;
    repeat (5) @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    chk("midreset_outputs",
        32'({busy, done, error, in_ready, out_valid, out_last, ccff_shift_en, ccff_head}),
        32'd0);
    pReset = 1'b0;
    s0 = shift_cnt;
    repeat (5) @(negedge prog_clk);
    chk("midreset_no_more_shifts", 32'(shift_cnt - s0), 32'd0);

    // Simultaneous starts: load wins; start_read while busy is ignored.
    start_load = 1'b1; start_read = 1'b1;
    @(negedge prog_clk);
    start_load = 1'b0; start_read = 1'b0;
    chk("both_start_load_wins", 32'({in_ready, ccff_shift_en}), 32'b10);
    start_read = 1'b1;
    @(negedge prog_clk);
    start_read = 1'b0;
    chk("busy_start_read_ignored", 32'({in_ready, ccff_shift_en}), 32'b10);
    for (int i = 0; i < 3; i++) begin
      int         k;
      logic [7:0] hb;
      load_word(lv[i].data, lv[i].last, k, hb);
      chk($sformatf("reload%0d_head_bits", i), 32'(hb), 32'(lv[i].exp_head));
    end
    chk("reload_done", 32'({done, error}), 32'b10);
    @(negedge prog_clk);
    chk("reload_chain_image", 32'(chain_q), 32'(exp_img));
    run_read(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_stream_loader.md
Name: ccff_stream_loader

Overview:
- Configuration-chain controller that sits directly upstream of a grid tile's ccff_head/ccff_tail chain.
- Load: accepts bitstream words on a valid/ready stream and serialises them into the chain, one bit per enabled prog_clk.
- Readback: recirculates the chain tail back into the head and returns the words on an output stream, so configuration is non-destructively verified.
- Drives the tile's prog_clk gating enable; chains of several tiles are treated as one CHAIN_LEN-bit chain.

Parameters:
- WORD_W, 8: bitstream word width, >=1.
- CHAIN_LEN, 64: total configuration bits in the attached chain, >=1; need not be a multiple of WORD_W.

Ports:
- prog_clk  in  1  configuration clock.
- pReset  in  1  synchronous active-high reset.
- start_load  in  1  begin load (sampled in IDLE only).
- start_read  in  1  begin readback (sampled in IDLE only).
- in_data  in  WORD_W  load word, LSB shifted first.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final word of bitstream.
- in_ready  out  1  loader accepts word this cycle.
- out_data  out  WORD_W  readback word; unused upper bits of final partial word = 0.
- out_valid  out  1  out_data valid.
- out_last  out  1  final readback word.
- out_ready  in  1  consumer accepts readback word.
- ccff_head  out  1  serial data into chain.
- ccff_tail  in  1  serial data from chain end.
- ccff_shift_en  out  1  chain shifts at the prog_clk edge ending a cycle with this high.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; cleared by next accepted start or pReset.

Behaviour:
- Clocking: one clock, prog_clk. Reset: pReset, synchronous, active-high.
- Reset values: state IDLE; all outputs 0; bit counter 0.
- States: IDLE, LWAIT, LSHIFT, RSHIFT, ROUT, DONE, ERR.
- IDLE:
  - start_load -> LWAIT; start_read -> RSHIFT.
  - Both asserted: load wins.
  - Accepting a start clears error and the bit counter.
- LWAIT:
  - in_ready=1, shift_en=0.
  - On in_valid&in_ready: capture word and in_last -> LSHIFT.
- LSHIFT:
  - shift_en=1; ccff_head = current word bit, LSB first.
  - Shifts k = min(WORD_W, CHAIN_LEN - count) bits; counter +1 per shift.
  - On the last of the k shifts:
    - count==CHAIN_LEN and captured last=1 -> DONE.
    - count==CHAIN_LEN and last=0 -> ERR (overlong stream; remaining input is not consumed).
    - count<CHAIN_LEN and last=1 -> ERR (short stream).
    - Otherwise -> LWAIT.
  - Excess bits of the final word beyond CHAIN_LEN are discarded, not shifted.
- Throughput: one word per k+1 cycles; in_ready is low throughout LSHIFT.
- First bit loaded ends at the tail after CHAIN_LEN shifts.
- ccff_head / ccff_shift_en in load states come from registers driven by state/counter; no combinational path from in_* to them.
- RSHIFT:
  - shift_en=1; ccff_head = ccff_tail (combinational mux, select registered), so the chain rotates.
  - ccff_tail is sampled at each enabled edge into out shift register bit position (count mod WORD_W).
  - After k bits -> ROUT.
  - After exactly CHAIN_LEN read shifts the chain contents equal their pre-read contents.
- ROUT:
  - shift_en=0; out_valid=1; out_data stable.
  - out_last=1 iff count==CHAIN_LEN.
  - On out_ready: -> RSHIFT, or -> DONE if out_last.
  - Backpressure holds indefinitely with no shifting.
- DONE: done=1 for one cycle -> IDLE.
- ERR: error set; shift_en=0; -> IDLE next cycle. error stays high in IDLE.
- start_* while busy: ignored.
- in_valid in non-LWAIT states: ignored, not consumed.
- pReset mid-operation:
  - Next cycle IDLE, shift_en=0, no further shifts, out_valid/in_ready=0.
  - Chain holds a partial image; not reported as error.
- ccff_head=0 whenever shift_en=0.

Test Plan:
- Load, CHAIN_LEN=20, WORD_W=8: words 0xA5, 0x3C, 0x0F(last) -> 20 shift_en cycles (8,8,4); head bit sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1; done pulse; error=0.
- Readback after the above: start_read -> out words 0xA5, 0x3C, 0x0F (out_last on third, bits 7:4 = 0); chain model unchanged afterwards; second readback identical.
- Short stream: 0xA5, 0x3C(last) -> ERR after 16 shifts; error=1, no done; next start_load clears error.
- Overlong stream: 0xA5, 0x3C, 0xFF (no last) -> after 20 shifts error=1; in_ready low thereafter; fourth word never accepted.
- Backpressure: hold out_ready=0 for 10 cycles in ROUT -> out_valid held, out_data stable, shift_en=0 throughout; data correct on release.
- Reset/contention: pReset after 5 load shifts -> next cycle all outputs 0, IDLE. start_load & start_read together -> load path taken. start_read while busy -> ignored.
